// File: rtl/cic_dec_sched.sv
// Decimation scheduler for the CIC decimator: counts integrator samples against a
// programmable ratio, strobes hold-register capture and time-shares one comb stage.
module cic_dec_sched #(
    parameter int RW        = 8,
    parameter int DEF_RATIO = 5,
    parameter int NSTG      = 2,
    parameter int COMB_LAT  = 1,
    localparam int SW       = (NSTG > 1) ? $clog2(NSTG) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          din_vld,
    input  logic [RW-1:0] ratio,
    input  logic          ratio_ld,
    input  logic          ovf_clr,
    output logic          cap_stb,
    output logic          comb_en,
    output logic          comb_ch,
    output logic [SW-1:0] comb_stg,
    output logic          rdy_i,
    output logic          rdy_q,
    output logic          busy,
    output logic          ovf,
    output logic          ratio_err,
    output logic [RW-1:0] cur_ratio
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [RW-1:0] cnt;
    logic [RW-1:0] pend_ratio;
    logic          pend_vld;
    logic          last_stg;
    logic          last_step;
    logic          free;
    logic          bnd;
    logic          ld_ok;
    logic [COMB_LAT-1:0] pipe_i;
    logic [COMB_LAT-1:0] pipe_q;

    assign last_stg  = (comb_stg == SW'(NSTG - 1));
    assign last_step = (state == RUN) && comb_ch && last_stg;
    assign free      = (state == IDLE) || last_step;
    assign bnd       = en && din_vld && (cnt == cur_ratio - 1'b1);
    assign ld_ok     = ratio_ld && (ratio >= RW'(2));

    // Busy and comb enable decode the single state flop, so they remain registered.
    assign comb_en = (state == RUN);
    assign busy    = (state == RUN);
    assign rdy_i   = pipe_i[COMB_LAT-1];
    assign rdy_q   = pipe_q[COMB_LAT-1];

    // Phase counter and ratio handling; a load in a boundary cycle bypasses pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            cur_ratio  <= RW'(DEF_RATIO);
            pend_ratio <= '0;
            pend_vld   <= 1'b0;
            ratio_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            ratio_err <= ratio_ld && (ratio < RW'(2));
            if (bnd)
                cnt <= '0;
            else if (en && din_vld)
                cnt <= cnt + 1'b1;
            if (bnd) begin
                pend_vld <= 1'b0;
                if (ld_ok)
                    cur_ratio <= ratio;
                else if (pend_vld)
                    cur_ratio <= pend_ratio;
            end else if (ld_ok) begin
                pend_vld   <= 1'b1;
                pend_ratio <= ratio;
            end
        end
    end

    // Sequencer: capture strobe, then I stages followed by Q stages, one per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cap_stb  <= 1'b0;
            comb_ch  <= 1'b0;
            comb_stg <= '0;
            ovf      <= 1'b0;
        end else begin
            cap_stb <= bnd && free;
            if (bnd && !free)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
            if (cap_stb) begin
                state    <= RUN;
                comb_ch  <= 1'b0;
                comb_stg <= '0;
            end else if (state == RUN) begin
                if (last_step) begin
                    state    <= IDLE;
                    comb_ch  <= 1'b0;
                    comb_stg <= '0;
                end else if (last_stg) begin
                    comb_ch  <= 1'b1;
                    comb_stg <= '0;
                end else begin
                    comb_stg <= comb_stg + 1'b1;
                end
            end
        end
    end

    // Ready strobes trail each channel's final stage by the comb pipeline latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_i <= '0;
            pipe_q <= '0;
        end else begin
            pipe_i[0] <= (state == RUN) && !comb_ch && last_stg;
            pipe_q[0] <= last_step;
            for (int k = 1; k < COMB_LAT; k++) begin
                pipe_i[k] <= pipe_i[k-1];
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_cic_dec_sched.sv
// Scoreboard bench for cic_dec_sched: stimulus queues expected strobes by cycle,
// a negedge monitor pops and compares whenever the DUT or the queue has an event.
module tb_cic_dec_sched;

    localparam int RW       = 8;
    localparam int NSTG     = 2;
    localparam int COMB_LAT = 1;

    typedef struct {
        int cyc;
        int ch;
        int stg;
    } step_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          din_vld;
    logic [RW-1:0] ratio;
    logic          ratio_ld;
    logic          ovf_clr;
    logic          cap_stb;
    logic          comb_en;
    logic          comb_ch;
    logic [0:0]    comb_stg;
    logic          rdy_i;
    logic          rdy_q;
    logic          busy;
    logic          ovf;
    logic          ratio_err;
    logic [RW-1:0] cur_ratio;

    int    cyc   = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    cap_q[$];
    int    rdyi_q[$];
    int    rdyq_q[$];
    step_t step_q[$];
    int    a, c, d, e, f;

    cic_dec_sched #(.RW(RW), .DEF_RATIO(5), .NSTG(NSTG), .COMB_LAT(COMB_LAT)) dut (
        .clk(clk), .rst(rst), .en(en), .din_vld(din_vld), .ratio(ratio),
        .ratio_ld(ratio_ld), .ovf_clr(ovf_clr), .cap_stb(cap_stb), .comb_en(comb_en),
        .comb_ch(comb_ch), .comb_stg(comb_stg), .rdy_i(rdy_i), .rdy_q(rdy_q),
        .busy(busy), .ovf(ovf), .ratio_err(ratio_err), .cur_ratio(cur_ratio)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Boundary in cycle t: capture, I steps, Q steps and both ready strobes.
    task automatic expect_sample(input int t);
        cap_q.push_back(t + 1);
        for (int s = 0; s < NSTG; s++) step_q.push_back('{t + 2 + s, 0, s});
        for (int s = 0; s < NSTG; s++) step_q.push_back('{t + 2 + NSTG + s, 1, s});
        rdyi_q.push_back(t + 1 + NSTG + COMB_LAT);
        rdyq_q.push_back(t + 1 + 2 * NSTG + COMB_LAT);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_zero"}, int'({cap_stb, comb_en, comb_ch, comb_stg, rdy_i, rdy_q,
                                     busy, ovf, ratio_err}), 0);
        check({name, "_ratio"}, int'(cur_ratio), 5);
    endtask

    always @(negedge clk) begin
        bit exp;
        exp = (cap_q.size() > 0) && (cap_q[0] == cyc);
        if (exp || cap_stb) begin
            check("cap_stb", int'(cap_stb), int'(exp));
            if (exp) void'(cap_q.pop_front());
        end
        exp = (rdyi_q.size() > 0) && (rdyi_q[0] == cyc);
        if (exp || rdy_i) begin
            check("rdy_i", int'(rdy_i), int'(exp));
            if (exp) void'(rdyi_q.pop_front());
        end
        exp = (rdyq_q.size() > 0) && (rdyq_q[0] == cyc);
        if (exp || rdy_q) begin
            check("rdy_q", int'(rdy_q), int'(exp));
            if (exp) void'(rdyq_q.pop_front());
        end
        exp = (step_q.size() > 0) && (step_q[0].cyc == cyc);
        if (exp || comb_en || busy) begin
            check("comb_en", int'(comb_en), int'(exp));
            check("busy", int'(busy), int'(exp));
            if (exp) begin
                check("comb_ch", int'(comb_ch), step_q[0].ch);
                check("comb_stg", int'(comb_stg), step_q[0].stg);
                void'(step_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; din_vld = 1'b0; ratio = '0; ratio_ld = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Defaults, then illegal load, then ratio 4 loaded mid-period causing overruns.
        a = cyc;
        for (int k = 0; k <= 41; k++) begin
            en = 1'b1; din_vld = (k <= 27); ratio_ld = 1'b0; ratio = '0; ovf_clr = (k == 40);
            if (k == 11) begin ratio_ld = 1'b1; ratio = 8'd1; end
            if (k == 16) begin ratio_ld = 1'b1; ratio = 8'd4; end
            if (k == 4 || k == 9 || k == 14 || k == 19 || k == 27) expect_sample(a + k);
            case (k)
                12: check("ratio_err_pulse", int'(ratio_err), 1);
                13: check("ratio_err_clear", int'(ratio_err), 0);
                15: check("ovf_idle", int'(ovf), 0);
                19: check("ratio_old", int'(cur_ratio), 5);
                20: check("ratio_new", int'(cur_ratio), 4);
                23: check("ovf_before", int'(ovf), 0);
                24: check("ovf_set", int'(ovf), 1);
                40: check("ovf_sticky", int'(ovf), 1);
                41: check("ovf_clr", int'(ovf), 0);
                default: ;
            endcase
            tick();
        end

        // Every-other-cycle samples, ratio 3 loaded on a boundary, en gap of 4 cycles.
        c = cyc;
        for (int k = 0; k <= 35; k++) begin
            en = !(k >= 21 && k <= 24); din_vld = (k % 2 == 0) && (k <= 28);
            ratio_ld = (k == 6); ratio = (k == 6) ? 8'd3 : 8'd0; ovf_clr = 1'b0;
            if (k == 6 || k == 12 || k == 18 || k == 28) expect_sample(c + k);
            if (k == 6) check("ratio_before_ld", int'(cur_ratio), 4);
            if (k == 7) check("ratio_immediate", int'(cur_ratio), 3);
            if (k == 30) check("ovf_none", int'(ovf), 0);
            tick();
        end

        // Overrun coinciding with ovf_clr: set wins; later clear.
        d = cyc;
        for (int k = 0; k <= 12; k++) begin
            en = 1'b1; din_vld = (k <= 5); ratio_ld = 1'b0; ovf_clr = (k == 5 || k == 8);
            if (k == 2) expect_sample(d + k);
            case (k)
                5: check("ovf_pre", int'(ovf), 0);
                6: check("ovf_set_wins", int'(ovf), 1);
                7: check("ovf_hold", int'(ovf), 1);
                9: check("ovf_clr2", int'(ovf), 0);
                default: ;
            endcase
            tick();
        end

        // Reset during the Q0 step aborts the sequence; no rdy_q may follow.
        e = cyc;
        cap_q.push_back(e + 3);
        step_q.push_back('{e + 4, 0, 0});
        step_q.push_back('{e + 5, 0, 1});
        step_q.push_back('{e + 6, 1, 0});
        rdyi_q.push_back(e + 6);
        for (int k = 0; k <= 5; k++) begin
            din_vld = (k <= 2);
            tick();
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        din_vld = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        tick();
        rst = 1'b0;
        f = cyc;
        for (int k = 0; k <= 14; k++) begin
            din_vld = (k <= 4);
            if (k == 4) expect_sample(f + k);
            if (k == 0) check("ratio_after_rst", int'(cur_ratio), 5);
            tick();
        end

        repeat (4) tick();
        check("leftover_cap", cap_q.size(), 0);
        check("leftover_step", step_q.size(), 0);
        check("leftover_rdy_i", rdyi_q.size(), 0);
        check("leftover_rdy_q", rdyq_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
